// File: rtl/regfile_port_ctrl.sv
// Initiator-side controller for a 2R/1W register file: in-order writeback FIFO,
// hazard-stalled operand fetch and a held operand-pair output.
module regfile_port_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int WB_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        freeze,
    input  logic                        rd_valid,
    output logic                        rd_ready,
    input  logic [ADDR_W-1:0]           rd_a_add,
    input  logic [ADDR_W-1:0]           rd_b_add,
    output logic                        op_valid,
    input  logic                        op_ready,
    output logic [DATA_W-1:0]           op_a,
    output logic [DATA_W-1:0]           op_b,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic [ADDR_W-1:0]           wb_add,
    input  logic [DATA_W-1:0]           wb_data,
    output logic [$clog2(WB_DEPTH):0]   wb_count,
    output logic                        rf_en,
    output logic [ADDR_W-1:0]           rf_write_add,
    output logic [DATA_W-1:0]           rf_write,
    output logic [ADDR_W-1:0]           rf_fir_add,
    output logic [ADDR_W-1:0]           rf_sec_add,
    input  logic [DATA_W-1:0]           rf_fir,
    input  logic [DATA_W-1:0]           rf_sec
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, OUT} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] fifo_add  [WB_DEPTH];
    logic [DATA_W-1:0] fifo_data [WB_DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] lat_a, lat_b;
    logic              push, pop, hazard, capture;

    // wb_ready looks only at occupancy, never at a same-cycle pop
    assign wb_ready     = (count < CNT_W'(WB_DEPTH));
    assign push         = wb_valid && wb_ready;
    assign pop          = (count != '0) && !freeze;
    assign rf_en        = pop;
    assign rf_write_add = fifo_add[head];
    assign rf_write     = fifo_data[head];
    assign wb_count     = count;
    assign rf_fir_add   = lat_a;
    assign rf_sec_add   = lat_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_add[tail]  <= wb_add;
            fifo_data[tail] <= wb_data;
        end
    end

    // The head counts as a hazard even while it is being written: the regfile
    // only reflects it from the following cycle.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                if (fifo_add[head + PTR_W'(i)] == lat_a ||
                    fifo_add[head + PTR_W'(i)] == lat_b)
                    hazard = 1'b1;
            end
        end
    end

    assign capture = (state == ISSUE) && !hazard && !freeze;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_valid) state_nxt = ISSUE;
            ISSUE:   if (capture)  state_nxt = OUT;
            OUT:     if (op_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_ready = (state == IDLE);
        op_valid = (state == OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_a <= '0;
            lat_b <= '0;
            op_a  <= '0;
            op_b  <= '0;
        end else begin
            if (state == IDLE && rd_valid) begin
                lat_a <= rd_a_add;
                lat_b <= rd_b_add;
            end
            if (capture) begin
                op_a <= rf_fir;
                op_b <= rf_sec;
            end
        end
    end
endmodule
